// File: rtl/mem_stage.sv
// Memory-access stage: performs LDUR/STUR over a req/ready handshake, resolves CBZ,
// and registers the writeback-stage outputs. Stalls upstream while an access is in flight.
//
// state  | meaning
// IDLE   | accepting a new instruction from execute each cycle
// ACCESS | memory request outstanding, waiting for dmem_ready
module mem_stage #(
    parameter int DATA_W      = 64,
    parameter int REG_AW      = 5,
    parameter int CHECK_ALIGN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              branch,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [REG_AW-1:0] rd,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              align_fault
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              dmem_we_q, dmem_we_d;
    logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              pc_src_q, pc_src_d;
    logic [DATA_W-1:0] pc_target_q, pc_target_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              align_fault_q, align_fault_d;

    logic is_mem_op;
    logic misaligned;

    assign is_mem_op  = mem_read | mem_write;
    assign misaligned = (CHECK_ALIGN != 0) && (alu_result[2:0] != 3'b000);

    always_comb begin
        state_d        = state_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        mem_to_reg_d   = mem_to_reg_q;
        pc_src_d       = 1'b0;
        pc_target_d    = pc_target_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        align_fault_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!is_mem_op) begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = reg_write;
                        wb_rd_d        = rd;
                        wb_data_d      = alu_result;
                        pc_src_d       = branch & zero;
                        pc_target_d    = branch_target;
                    end else if (misaligned) begin
                        // Dropped access still retires so the pipeline sees one result per instruction.
                        align_fault_d  = 1'b1;
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = 1'b0;
                        wb_rd_d        = rd;
                        wb_data_d      = alu_result;
                    end else begin
                        state_d      = ACCESS;
                        dmem_we_d    = mem_write;
                        dmem_addr_d  = alu_result;
                        dmem_wdata_d = store_data;
                        rd_d         = rd;
                        reg_write_d  = reg_write;
                        mem_to_reg_d = mem_to_reg;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ready) begin
                    state_d        = IDLE;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = reg_write_q & ~dmem_we_q;
                    wb_rd_d        = rd_q;
                    wb_data_d      = dmem_we_q ? dmem_addr_q : dmem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            pc_src_q       <= 1'b0;
            pc_target_q    <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            align_fault_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
            pc_src_q       <= pc_src_d;
            pc_target_q    <= pc_target_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            align_fault_q  <= align_fault_d;
        end
    end

    // Load data always comes from memory; the latched select is kept for debug visibility.
    logic unused_mem_to_reg;
    assign unused_mem_to_reg = mem_to_reg_q;

    assign stall        = (state_q == ACCESS);
    assign dmem_req     = (state_q == ACCESS);
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign pc_src       = pc_src_q;
    assign pc_target    = pc_target_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign align_fault  = align_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU, LDUR with waits, STUR, CBZ, misalignment and
// reset during an outstanding access, each against hand-computed values.
module tb_mem_stage;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] store_data;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic [DATA_W-1:0] branch_target;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_to_reg;
    logic              stall;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;
    logic              pc_src;
    logic [DATA_W-1:0] pc_target;
    logic              wb_valid;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              align_fault;

    int n_chk  = 0;
    int n_pass = 0;

    mem_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CHECK_ALIGN(1)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .alu_result(alu_result),
        .zero(zero), .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .branch_target(branch_target), .rd(rd), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .pc_src(pc_src), .pc_target(pc_target),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .align_fault(align_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ex_valid = 0; alu_result = '0; zero = 0; store_data = '0; mem_read = 0;
        mem_write = 0; branch = 0; branch_target = '0; rd = '0; reg_write = 0;
        mem_to_reg = 0; dmem_ready = 0; dmem_rdata = '0;
    endtask

    initial begin
        clear_in();
        reset = 1;
        tick(); tick();
        check("rst_stall", stall, 0);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_pc_src", pc_src, 0);
        check("rst_pc_target", pc_target, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rw", wb_reg_write, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_fault", align_fault, 0);
        reset = 0;

        // ALU op
        ex_valid = 1; alu_result = 64'h1234; rd = 3; reg_write = 1;
        check("alu_stall_pre", stall, 0);
        tick();
        ex_valid = 0;
        check("alu_wb_valid", wb_valid, 1);
        check("alu_wb_rd", wb_rd, 3);
        check("alu_wb_data", wb_data, 64'h1234);
        check("alu_wb_rw", wb_reg_write, 1);
        check("alu_stall", stall, 0);
        check("alu_pc_src", pc_src, 0);
        tick();
        check("alu_wb_pulse", wb_valid, 0);
        check("alu_wb_hold", wb_data, 64'h1234);

        // LDUR with two wait cycles; inputs change during ACCESS and must be ignored
        clear_in();
        ex_valid = 1; alu_result = 64'h40; mem_read = 1; mem_to_reg = 1; rd = 7; reg_write = 1;
        tick();
        mem_read = 0; mem_to_reg = 0; alu_result = 64'h999; rd = 12;
        for (int i = 0; i < 3; i++) begin
            check("ld_req", dmem_req, 1);
            check("ld_stall", stall, 1);
            check("ld_addr", dmem_addr, 64'h40);
            check("ld_we", dmem_we, 0);
            check("ld_wb_idle", wb_valid, 0);
            if (i == 2) begin
                dmem_ready = 1; dmem_rdata = 64'hDEADBEEF;
            end
            tick();
        end
        clear_in();
        check("ld_wb_valid", wb_valid, 1);
        check("ld_wb_data", wb_data, 64'hDEADBEEF);
        check("ld_wb_rd", wb_rd, 7);
        check("ld_wb_rw", wb_reg_write, 1);
        check("ld_stall_done", stall, 0);
        check("ld_req_done", dmem_req, 0);
        tick();
        check("ld_wb_pulse", wb_valid, 0);

        // dmem_ready while idle is ignored
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        check("idle_ready_wb", wb_valid, 0);
        check("idle_ready_stall", stall, 0);

        // STUR zero-wait; reg_write must be masked for a store
        ex_valid = 1; alu_result = 64'h80; store_data = 64'h55; mem_write = 1; rd = 9; reg_write = 1;
        tick();
        clear_in();
        dmem_ready = 1;
        check("st_req", dmem_req, 1);
        check("st_we", dmem_we, 1);
        check("st_wdata", dmem_wdata, 64'h55);
        check("st_addr", dmem_addr, 64'h80);
        tick();
        dmem_ready = 0;
        check("st_wb_valid", wb_valid, 1);
        check("st_wb_rw", wb_reg_write, 0);
        check("st_wb_data", wb_data, 64'h80);
        check("st_req_done", dmem_req, 0);
        check("st_stall_done", stall, 0);

        // CBZ taken, then not taken
        ex_valid = 1; branch = 1; zero = 1; branch_target = 64'h200;
        tick();
        ex_valid = 0;
        check("cbz_pc_src", pc_src, 1);
        check("cbz_pc_target", pc_target, 64'h200);
        tick();
        check("cbz_pulse", pc_src, 0);
        ex_valid = 1; zero = 0; branch_target = 64'h300;
        tick();
        ex_valid = 0;
        check("cbz_nt_pc_src", pc_src, 0);
        check("cbz_nt_wb_valid", wb_valid, 1);

        // Branch combined with a load: only the load happens
        clear_in();
        ex_valid = 1; branch = 1; zero = 1; branch_target = 64'h500;
        mem_read = 1; alu_result = 64'h100; rd = 2; reg_write = 1;
        tick();
        clear_in();
        check("brmem_pc_src", pc_src, 0);
        check("brmem_req", dmem_req, 1);
        dmem_ready = 1; dmem_rdata = 64'h77;
        tick();
        clear_in();
        check("brmem_wb_data", wb_data, 64'h77);
        check("brmem_pc_src2", pc_src, 0);

        // Misaligned LDUR
        ex_valid = 1; mem_read = 1; alu_result = 64'h43; rd = 5; reg_write = 1;
        tick();
        clear_in();
        check("mis_req", dmem_req, 0);
        check("mis_fault", align_fault, 1);
        check("mis_wb_valid", wb_valid, 1);
        check("mis_wb_rw", wb_reg_write, 0);
        check("mis_stall", stall, 0);
        tick();
        check("mis_fault_pulse", align_fault, 0);
        check("mis_req2", dmem_req, 0);

        // Reset during ACCESS abandons the request
        ex_valid = 1; mem_read = 1; alu_result = 64'h48; rd = 6; reg_write = 1;
        tick();
        clear_in();
        check("rsta_req", dmem_req, 1);
        reset = 1;
        tick();
        reset = 0;
        check("rsta_req_off", dmem_req, 0);
        check("rsta_stall", stall, 0);
        check("rsta_wb_valid", wb_valid, 0);
        check("rsta_fault", align_fault, 0);
        ex_valid = 1; alu_result = 64'hABC; rd = 4; reg_write = 1;
        tick();
        clear_in();
        check("post_wb_valid", wb_valid, 1);
        check("post_wb_data", wb_data, 64'hABC);
        check("post_wb_rd", wb_rd, 4);
        check("post_stall", stall, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
